uart_rx_frame: RTL and testbench
================================

Name: uart_rx_frame

Overview:
Parametrised successor to the fixed 8N1 UART receiver. It supports configurable data width, parity and stop-bit count, and reports parity, framing, overrun and line-break errors. A one-entry valid/ready output register decouples it from the downstream image-buffer writer. It sits between the Basys3 RsRx pin and the pixel-loading logic.

Parameters:
CLKS_PER_BIT, 868, clk cycles per bit (115200 baud at 100 MHz); legal range 8..65535.
DATA_BITS, 8, data bits per frame, LSB first; legal range 5..9.
PARITY_MODE, 0, 0 = none, 1 = odd, 2 = even.
STOP_BITS, 1, number of stop bits; 1 or 2.
SYNC_STAGES, 2, RsRx synchroniser depth; 2..4.

Ports:
clk  in  1  system clock.
rst  in  1  asynchronous, active-high reset.
RsRx  in  1  serial line; idle high.
rx_data  out  DATA_BITS  received word.
rx_valid  out  1  output register holds an unread frame.
rx_ready  in  1  consumer accepts the frame when rx_valid and rx_ready are both high.
parity_err  out  1  parity mismatch on the rx_data frame; always 0 when PARITY_MODE = 0.
frame_err  out  1  a sampled stop bit was 0.
break_det  out  1  all data bits, the parity bit (if present) and the stop bit(s) were 0.
overrun  out  1  at least one frame was dropped while rx_valid was high.
busy  out  1  FSM is not in IDLE.

Behaviour:
- Reset (async assert, sync release):
  - all outputs 0; FSM to IDLE.
  - synchroniser flops preset to 1; bit counter, index and shift register cleared.
  - a reset mid-frame aborts the frame with no output.
- Bit counter width is $clog2(CLKS_PER_BIT). All sampling uses the last synchroniser stage (rx_s).
- IDLE: busy = 0. When rx_s = 0, go to START with the counter at 0.
- START:
  - count to (CLKS_PER_BIT-1)/2.
  - if rx_s = 0 there, clear the counter and go to DATA; otherwise treat it as a glitch and return to IDLE.
- DATA:
  - every CLKS_PER_BIT cycles, shift rx_s into bit[index], LSB first.
  - after index DATA_BITS-1, go to PARITY if PARITY_MODE != 0, else to STOP.
- PARITY:
  - sample one bit after CLKS_PER_BIT cycles.
  - error if the XOR of the data bits and the parity bit is 0 (odd mode) or 1 (even mode).
- STOP:
  - sample STOP_BITS bits, each CLKS_PER_BIT cycles apart.
  - frame_err is set if any sampled stop bit is 0.
  - after the last sample, go to DONE.
- DONE: one cycle. Commit the frame to the output register as described below, then:
  - go to IDLE if rx_s = 1;
  - otherwise go to WAIT_IDLE, so a held-low line cannot retrigger.
- WAIT_IDLE: stay until rx_s = 1, then go to IDLE.
- Latency: rx_valid rises on the clk edge after the cycle in which the final stop sample is taken.
- Output register commit rules:
  - Register empty (rx_valid = 0), or accepted in the same cycle (rx_valid & rx_ready): load rx_data and the three error flags, set rx_valid = 1. overrun keeps its sticky value from the previous word, then clears once this word is accepted.
  - Register full and not accepted this cycle: discard the new frame; rx_data and flags unchanged; set overrun = 1.
  - Accept with no commit: rx_valid falls next edge. rx_data and flags hold their values; overrun clears.
- rx_data, parity_err, frame_err, break_det and overrun are stable while rx_valid = 1.

Optional Feature:
Macro: UART_RX_MAJORITY_EN.
- Defined: each data, parity and stop sample is the 2-of-3 majority of rx_s taken at mid-1, mid and mid+1 cycles. The start-bit check also uses the majority at its mid point. Sample and latency timing shift by +1 cycle.
- Not defined: single-sample behaviour exactly as specified in Behaviour.

Test Plan:
All scenarios use CLKS_PER_BIT = 16.
1. Defaults (8N1): send 0xA5 with rx_ready tied 1 -> rx_valid high for exactly 1 cycle, rx_data = 0xA5, all error flags 0.
2. PARITY_MODE = 2 (even): send 0x03 with parity bit 0 -> parity_err = 0. Send 0x03 with parity bit 1 -> parity_err = 1, rx_data = 0x03.
3. STOP_BITS = 2: send 0x5A with the second stop bit driven 0 -> frame_err = 1. Hold line low for 40 bit times -> break_det = 1 once, busy stays 1 until line high, and no second frame.
4. rx_ready = 0: send 0x11 then 0x22 -> rx_data stays 0x11, overrun = 1. Pulse rx_ready -> rx_valid = 0, overrun = 0. Then send 0x33 -> rx_data = 0x33, overrun = 0.
5. Simultaneous events: raise rx_ready in the DONE cycle of the second frame -> rx_data = second word, rx_valid stays 1, overrun = 0. Also: 0-pulse of 4 cycles on idle line -> START aborts, no rx_valid.
6. Assert rst at data bit 4 of 0xFF, release, then send 0x81 -> no output for the aborted frame, rx_data = 0x81. With UART_RX_MAJORITY_EN: a single-cycle 1-glitch at the mid-sample of bit 0 of 0x00 -> rx_data = 0x00.

Source files
------------

// File: rtl/uart_rx_frame.sv
// uart_rx_frame: parametrised UART receiver with parity, stop-bit, overrun and
// line-break reporting, feeding a one-entry valid/ready output register.
//
// Optional build macro: UART_RX_MAJORITY_EN. When defined, every bit decision
// (start check, data, parity, stop) is the 2-of-3 majority of rx_s taken at
// mid-1, mid and mid+1. All decisions then land one cycle later.
//
// Ports:
//   clk        system clock
//   rst        asynchronous active-high reset
//   RsRx       serial line, idle high
//   rx_data    received word (LSB first on the line)
//   rx_valid   output register holds an unread frame
//   rx_ready   consumer accepts when rx_valid & rx_ready
//   parity_err parity mismatch on the held frame (0 when PARITY_MODE = 0)
//   frame_err  a sampled stop bit was 0
//   break_det  data, parity and stop bits were all 0
//   overrun    at least one frame was dropped while rx_valid was high
//   busy       receive FSM is not idle
module uart_rx_frame #(
   parameter int unsigned CLKS_PER_BIT = 868,
   parameter int unsigned DATA_BITS    = 8,
   parameter int unsigned PARITY_MODE  = 0,
   parameter int unsigned STOP_BITS    = 1,
   parameter int unsigned SYNC_STAGES  = 2
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 RsRx,
   output logic [DATA_BITS-1:0] rx_data,
   output logic                 rx_valid,
   input  logic                 rx_ready,
   output logic                 parity_err,
   output logic                 frame_err,
   output logic                 break_det,
   output logic                 overrun,
   output logic                 busy
);

   localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
   localparam int unsigned IDX_W = $clog2(DATA_BITS);
`ifdef UART_RX_MAJORITY_EN
   localparam int unsigned START_CNT = (CLKS_PER_BIT - 1) / 2 + 1;
`else
   localparam int unsigned START_CNT = (CLKS_PER_BIT - 1) / 2;
`endif
   localparam logic [CNT_W-1:0] BIT_END   = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [CNT_W-1:0] START_END = CNT_W'(START_CNT);
   localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DATA_BITS - 1);
   localparam logic [IDX_W-1:0] STOP_LAST = IDX_W'(STOP_BITS - 1);

   typedef enum logic [2:0] {
      S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_DONE, S_WAIT_IDLE
   } state_t;

   state_t                 state_q, state_d;
   logic [SYNC_STAGES-1:0] sync_q;
   logic                   rx_s;
   logic                   bit_s_c;
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic [IDX_W-1:0]       idx_q, idx_d;
   logic [DATA_BITS-1:0]   shift_q, shift_d;
   logic                   par_q, par_d;
   logic                   zero_q, zero_d;
   logic                   ferr_q, ferr_d;
   logic                   commit_c;
   logic                   tick_c;
   logic                   pe_c;

   // Input synchroniser, preset to the idle level
   always_ff @(posedge clk or posedge rst) begin
      if (rst) sync_q <= '1;
      else     sync_q <= {sync_q[SYNC_STAGES-2:0], RsRx};
   end
   assign rx_s = sync_q[SYNC_STAGES-1];

`ifdef UART_RX_MAJORITY_EN
   // Two previous rx_s values; with the current one they form the vote window
   logic [1:0] hist_q;
   always_ff @(posedge clk or posedge rst) begin
      if (rst) hist_q <= '1;
      else     hist_q <= {hist_q[0], rx_s};
   end
   assign bit_s_c = (hist_q[1] & hist_q[0]) | (hist_q[1] & rx_s) | (hist_q[0] & rx_s);
`else
   assign bit_s_c = rx_s;
`endif

   assign tick_c = (cnt_q == BIT_END);

   // Parity accumulator holds XOR of data and parity bits
   always_comb begin
      pe_c = 1'b0;
      if (PARITY_MODE == 1)      pe_c = ~par_q;
      else if (PARITY_MODE == 2) pe_c = par_q;
   end

   // Receive FSM state and datapath registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         idx_q   <= '0;
         shift_q <= '0;
         par_q   <= 1'b0;
         zero_q  <= 1'b0;
         ferr_q  <= 1'b0;
         busy    <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         shift_q <= shift_d;
         par_q   <= par_d;
         zero_q  <= zero_d;
         ferr_q  <= ferr_d;
         busy    <= (state_d != S_IDLE);
      end
   end

   // Next-state and datapath update
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      idx_d    = idx_q;
      shift_d  = shift_q;
      par_d    = par_q;
      zero_d   = zero_q;
      ferr_d   = ferr_q;
      commit_c = 1'b0;
      case (state_q)
         S_IDLE: begin
            cnt_d = '0;
            if (!rx_s) state_d = S_START;
         end
         S_START: begin
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == START_END) begin
               cnt_d   = '0;
               idx_d   = '0;
               par_d   = 1'b0;
               zero_d  = 1'b1;
               ferr_d  = 1'b0;
               // A high line at the start midpoint was a glitch
               state_d = bit_s_c ? S_IDLE : S_DATA;
            end
         end
         S_DATA: begin
            cnt_d = cnt_q + CNT_W'(1);
            if (tick_c) begin
               cnt_d   = '0;
               shift_d = {bit_s_c, shift_q[DATA_BITS-1:1]};
               par_d   = par_q ^ bit_s_c;
               zero_d  = zero_q & ~bit_s_c;
               idx_d   = idx_q + IDX_W'(1);
               if (idx_q == IDX_LAST) begin
                  idx_d   = '0;
                  state_d = (PARITY_MODE != 0) ? S_PARITY : S_STOP;
               end
            end
         end
         S_PARITY: begin
            cnt_d = cnt_q + CNT_W'(1);
            if (tick_c) begin
               cnt_d   = '0;
               par_d   = par_q ^ bit_s_c;
               zero_d  = zero_q & ~bit_s_c;
               state_d = S_STOP;
            end
         end
         S_STOP: begin
            cnt_d = cnt_q + CNT_W'(1);
            if (tick_c) begin
               cnt_d  = '0;
               ferr_d = ferr_q | ~bit_s_c;
               zero_d = zero_q & ~bit_s_c;
               idx_d  = idx_q + IDX_W'(1);
               if (idx_q == STOP_LAST) begin
                  idx_d   = '0;
                  state_d = S_DONE;
               end
            end
         end
         S_DONE: begin
            commit_c = 1'b1;
            // A line still held low must not look like a new start bit
            state_d  = rx_s ? S_IDLE : S_WAIT_IDLE;
         end
         S_WAIT_IDLE: begin
            if (rx_s) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // One-entry output register with sticky overrun
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rx_data    <= '0;
         rx_valid   <= 1'b0;
         parity_err <= 1'b0;
         frame_err  <= 1'b0;
         break_det  <= 1'b0;
         overrun    <= 1'b0;
      end else if (commit_c && (!rx_valid || rx_ready)) begin
         rx_data    <= shift_q;
         parity_err <= pe_c;
         frame_err  <= ferr_q;
         break_det  <= zero_q;
         rx_valid   <= 1'b1;
      end else if (commit_c) begin
         overrun    <= 1'b1;
      end else if (rx_valid && rx_ready) begin
         rx_valid   <= 1'b0;
         overrun    <= 1'b0;
      end
   end

endmodule

// File: tb/tb_uart_rx_frame.sv
// Directed bench for uart_rx_frame: an 8N1 instance (a) and an even-parity,
// two-stop-bit instance (b), both at 16 clocks per bit.
module tb_uart_rx_frame;

   localparam int unsigned CPB = 16;
`ifdef UART_RX_MAJORITY_EN
   localparam int unsigned DONE_OFS = 156;
`else
   localparam int unsigned DONE_OFS = 155;
`endif

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       line_a = 1'b1, line_b = 1'b1;
   logic       rdy_a = 1'b1, rdy_b = 1'b1;
   logic [7:0] data_a, data_b;
   logic       valid_a, pe_a, fe_a, bd_a, ov_a, busy_a;
   logic       valid_b, pe_b, fe_b, bd_b, ov_b, busy_b;

   int n_cmp = 0;
   int n_err = 0;

   // Frame monitors: count valid cycles and rising edges, capture on rise
   int         rise_a = 0, cyc_a = 0, rise_b = 0, cyc_b = 0;
   logic       prev_a = 1'b0, prev_b = 1'b0;
   logic [7:0] cap_data_a = '0, cap_data_b = '0;
   logic [3:0] cap_flg_a = '0, cap_flg_b = '0;   // {parity, frame, break, overrun}

   always #5 clk = ~clk;

   uart_rx_frame #(.CLKS_PER_BIT(CPB)) dut_a (
      .clk(clk), .rst(rst), .RsRx(line_a), .rx_data(data_a), .rx_valid(valid_a),
      .rx_ready(rdy_a), .parity_err(pe_a), .frame_err(fe_a), .break_det(bd_a),
      .overrun(ov_a), .busy(busy_a));

   uart_rx_frame #(.CLKS_PER_BIT(CPB), .PARITY_MODE(2), .STOP_BITS(2)) dut_b (
      .clk(clk), .rst(rst), .RsRx(line_b), .rx_data(data_b), .rx_valid(valid_b),
      .rx_ready(rdy_b), .parity_err(pe_b), .frame_err(fe_b), .break_det(bd_b),
      .overrun(ov_b), .busy(busy_b));

   always @(negedge clk) begin
      if (valid_a) begin
         cyc_a <= cyc_a + 1;
         if (!prev_a) begin
            rise_a     <= rise_a + 1;
            cap_data_a <= data_a;
            cap_flg_a  <= {pe_a, fe_a, bd_a, ov_a};
         end
      end
      prev_a <= valid_a;
      if (valid_b) begin
         cyc_b <= cyc_b + 1;
         if (!prev_b) begin
            rise_b     <= rise_b + 1;
            cap_data_b <= data_b;
            cap_flg_b  <= {pe_b, fe_b, bd_b, ov_b};
         end
      end
      prev_b <= valid_b;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Drive bits[0..n-1] one bit time each, then return the line to idle
   task automatic send_bits(input bit sel, input logic [15:0] bits, input int n);
      for (int i = 0; i < n; i++) begin
         if (sel) line_b = bits[i];
         else     line_a = bits[i];
         repeat (CPB) @(negedge clk);
      end
      if (sel) line_b = 1'b1;
      else     line_a = 1'b1;
   endtask

   int r0, c0;

   initial begin
      // Reset state
      idle(3); #1;
      chk("reset_a", {17'd0, valid_a, pe_a, fe_a, bd_a, ov_a, busy_a, data_a}, 32'd0);
      chk("reset_b", {17'd0, valid_b, pe_b, fe_b, bd_b, ov_b, busy_b, data_b}, 32'd0);
      rst = 1'b0;
      idle(5);

      // 8N1 0xA5 with ready tied high
      r0 = rise_a; c0 = cyc_a;
      send_bits(0, {6'd0, 1'b1, 8'hA5, 1'b0}, 10);
      idle(4); #1;
      chk("a5_rises", rise_a - r0, 1);
      chk("a5_valid_cycles", cyc_a - c0, 1);
      chk("a5_data", cap_data_a, 8'hA5);
      chk("a5_flags", cap_flg_a, 4'b0000);
      chk("a5_busy", busy_a, 1'b0);

      // Even parity, good parity bit
      @(negedge clk);
      r0 = rise_b;
      send_bits(1, {4'd0, 1'b1, 1'b1, 1'b0, 8'h03, 1'b0}, 12);
      idle(4); #1;
      chk("par_ok_rises", rise_b - r0, 1);
      chk("par_ok_data", cap_data_b, 8'h03);
      chk("par_ok_flags", cap_flg_b, 4'b0000);

      // Even parity, wrong parity bit
      @(negedge clk);
      send_bits(1, {4'd0, 1'b1, 1'b1, 1'b1, 8'h03, 1'b0}, 12);
      idle(4); #1;
      chk("par_bad_data", cap_data_b, 8'h03);
      chk("par_bad_flags", cap_flg_b, 4'b1000);

      // Second stop bit low
      @(negedge clk);
      r0 = rise_b;
      send_bits(1, {4'd0, 1'b0, 1'b1, 1'b0, 8'h5A, 1'b0}, 12);
      idle(6); #1;
      chk("fe_rises", rise_b - r0, 1);
      chk("fe_data", cap_data_b, 8'h5A);
      chk("fe_flags", cap_flg_b, 4'b0100);
      chk("fe_busy", busy_b, 1'b0);

      // Line break: low for 40 bit times
      @(negedge clk);
      r0 = rise_b;
      line_b = 1'b0;
      idle(40 * CPB); #1;
      chk("brk_busy_low", busy_b, 1'b1);
      chk("brk_rises", rise_b - r0, 1);
      chk("brk_data", cap_data_b, 8'h00);
      chk("brk_flags", cap_flg_b, 4'b0110);
      line_b = 1'b1;
      idle(200); #1;
      chk("brk_busy_high", busy_b, 1'b0);
      chk("brk_no_second", rise_b - r0, 1);

      // Overrun with consumer stalled
      @(negedge clk);
      rdy_a = 1'b0;
      send_bits(0, {6'd0, 1'b1, 8'h11, 1'b0}, 10);
      idle(2); #1;
      chk("ov_first", {valid_a, ov_a, data_a}, {1'b1, 1'b0, 8'h11});
      @(negedge clk);
      send_bits(0, {6'd0, 1'b1, 8'h22, 1'b0}, 10);
      idle(2); #1;
      chk("ov_held", {valid_a, ov_a, data_a}, {1'b1, 1'b1, 8'h11});
      rdy_a = 1'b1;
      @(negedge clk);
      rdy_a = 1'b0;
      #1;
      chk("ov_accept", {valid_a, ov_a, data_a}, {1'b0, 1'b0, 8'h11});
      @(negedge clk);
      send_bits(0, {6'd0, 1'b1, 8'h33, 1'b0}, 10);
      idle(2); #1;
      chk("ov_next", {valid_a, ov_a, data_a}, {1'b1, 1'b0, 8'h33});
      rdy_a = 1'b1;
      @(negedge clk);
      rdy_a = 1'b0;

      // Accept in the same cycle as the next commit
      @(negedge clk);
      send_bits(0, {6'd0, 1'b1, 8'h44, 1'b0}, 10);
      idle(2); #1;
      chk("sim_first", {valid_a, data_a}, {1'b1, 8'h44});
      @(negedge clk);
      fork
         send_bits(0, {6'd0, 1'b1, 8'h55, 1'b0}, 10);
         begin
            repeat (DONE_OFS) @(negedge clk);
            #1;
            chk("sim_pre", {valid_a, data_a}, {1'b1, 8'h44});
            rdy_a = 1'b1;
            @(negedge clk);
            rdy_a = 1'b0;
            #1;
            chk("sim_after", {valid_a, ov_a, data_a}, {1'b1, 1'b0, 8'h55});
         end
      join
      rdy_a = 1'b1;
      idle(4);

      // Short low pulse on an idle line
      r0 = rise_a;
      line_a = 1'b0;
      idle(4);
      line_a = 1'b1;
      #1;
      chk("glitch_busy", busy_a, 1'b1);
      idle(40); #1;
      chk("glitch_idle", busy_a, 1'b0);
      chk("glitch_no_frame", rise_a - r0, 0);

      // Reset in the middle of data bit 4
      @(negedge clk);
      r0 = rise_a;
      fork
         send_bits(0, {6'd0, 1'b1, 8'hFF, 1'b0}, 10);
         begin
            repeat (5 * CPB + 8) @(negedge clk);
            rst = 1'b1;
            idle(2); #1;
            chk("rst_mid", {valid_a, busy_a}, 2'b00);
            rst = 1'b0;
         end
      join
      idle(20); #1;
      chk("rst_no_frame", rise_a - r0, 0);
      chk("rst_idle", busy_a, 1'b0);
      @(negedge clk);
      send_bits(0, {6'd0, 1'b1, 8'h81, 1'b0}, 10);
      idle(4); #1;
      chk("rst_next_rises", rise_a - r0, 1);
      chk("rst_next_data", cap_data_a, 8'h81);

      // One-cycle high glitch at the bit-0 midpoint of 0x00
      @(negedge clk);
      fork
         send_bits(0, {6'd0, 1'b1, 8'h00, 1'b0}, 10);
         begin
            repeat (24) @(negedge clk);
            line_a = 1'b1;
            @(negedge clk);
            line_a = 1'b0;
         end
      join
      idle(4); #1;
`ifdef UART_RX_MAJORITY_EN
      chk("mid_glitch_data", cap_data_a, 8'h00);
`else
      chk("mid_glitch_data", cap_data_a, 8'h01);
`endif
      chk("mid_glitch_flags", cap_flg_a, 4'b0000);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
